// File: rtl/flash_mp_region_scan.sv
// Flash memory-protection checker: walks the region table one entry per cycle,
// then holds the permission result until the consumer takes it.
module flash_mp_region_scan #(
  parameter int NumRegions = 8,
  parameter int AddrW      = 16,
  parameter int ErrCntW    = 8,
  localparam int IdxW      = (NumRegions > 1) ? $clog2(NumRegions) : 1,
  localparam int CfgW      = 2 * AddrW + 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CfgW-1:0]    region_cfg_i [NumRegions],
  input  logic [2:0]         default_cfg_i,
  input  logic               req_i,
  input  logic [AddrW-1:0]   req_addr_i,
  input  logic [1:0]         req_op_i,
  output logic               ready_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               allow_o,
  output logic               hit_o,
  output logic [IdxW-1:0]    hit_idx_o,
  output logic [ErrCntW-1:0] err_cnt_o
);

  // state | meaning
  // IDLE  | waiting for a request, ready_o high
  // SCAN  | comparing one region per cycle, result acted on one cycle later
  // RESP  | result held until rsp_ready_i
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  typedef struct packed {
    logic             en;
    logic             rd_en;
    logic             prog_en;
    logic             erase_en;
    logic [AddrW-1:0] base;
    logic [AddrW:0]   size;
  } region_cfg_t;

  typedef struct packed {
    logic rd_en;
    logic prog_en;
    logic erase_en;
  } default_cfg_t;

  state_t              state_q, state_d;
  logic [IdxW-1:0]     idx_q;
  logic [AddrW-1:0]    addr_q;
  logic [1:0]          op_q;
  logic                m_vld_q, m_hit_q, m_allow_q, m_last_q;
  logic [IdxW-1:0]     m_idx_q;
  logic                hit_q, allow_q;
  logic [IdxW-1:0]     hit_idx_q;
  logic [ErrCntW-1:0]  err_q;

  region_cfg_t  cur_cfg;
  default_cfg_t dflt_cfg;
  logic         cur_match, is_last, scan_done;

  function automatic logic op_allow(input logic [1:0] op, input logic rd, input logic pg,
                                    input logic er);
    case (op)
      2'd0:    op_allow = rd;
      2'd1:    op_allow = pg;
      2'd2:    op_allow = er;
      default: op_allow = 1'b0;
    endcase
  endfunction

  assign cur_cfg  = region_cfg_t'(region_cfg_i[idx_q]);
  assign dflt_cfg = default_cfg_t'(default_cfg_i);
  // Upper bound is widened by one bit so base+size never wraps; size=0 cannot match.
  assign cur_match = cur_cfg.en && (addr_q >= cur_cfg.base) &&
                     ({1'b0, addr_q} < ({1'b0, cur_cfg.base} + cur_cfg.size));
  assign is_last   = (idx_q == IdxW'(NumRegions - 1));
  assign scan_done = (state_q == SCAN) && m_vld_q && (m_hit_q || m_last_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = SCAN;
      SCAN:    if (scan_done) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  assign allow_o   = allow_q;
  assign hit_o     = hit_q;
  assign hit_idx_o = hit_idx_q;
  assign err_cnt_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      m_vld_q   <= 1'b0;
      m_hit_q   <= 1'b0;
      m_allow_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_idx_q   <= '0;
      hit_q     <= 1'b0;
      allow_q   <= 1'b0;
      hit_idx_q <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= req_addr_i;
            op_q    <= req_op_i;
            idx_q   <= '0;
            m_vld_q <= 1'b0;
          end
        end
        SCAN: begin
          m_vld_q   <= 1'b1;
          m_hit_q   <= cur_match;
          m_allow_q <= op_allow(op_q, cur_cfg.rd_en, cur_cfg.prog_en, cur_cfg.erase_en);
          m_idx_q   <= idx_q;
          m_last_q  <= is_last;
          if (!is_last) idx_q <= idx_q + IdxW'(1);
          if (scan_done) begin
            hit_q     <= m_hit_q;
            hit_idx_q <= m_hit_q ? m_idx_q : '0;
            allow_q   <= m_hit_q ? m_allow_q
                                 : op_allow(op_q, dflt_cfg.rd_en, dflt_cfg.prog_en,
                                            dflt_cfg.erase_en);
          end
        end
        RESP: begin
          if (rsp_ready_i && !allow_q && (err_q != {ErrCntW{1'b1}}))
            err_q <= err_q + ErrCntW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/flash_mp_region_scan.md
FLASH_MP_REGION_SCAN -- requirements
Module: flash_mp_region_scan

Interface
REQ-001 SHALL have parameter NumRegions, default 8, number of configurable protection regions (1..16).
REQ-002 SHALL have parameter AddrW, default 16, page-address width.
REQ-003 SHALL have parameter ErrCntW, default 8, width of the denied-request counter.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port region_cfg_i, input, NumRegions-entry unpacked array of packed struct {en, rd_en, prog_en, erase_en, base[AddrW], size[AddrW+1]}, per-region attributes.
REQ-007 SHALL have port default_cfg_i, input, packed struct {rd_en, prog_en, erase_en}, attributes applied when no region matches.
REQ-008 SHALL have port req_i, input, 1, access request valid.
REQ-009 SHALL have port req_addr_i, input, AddrW, page address to check.
REQ-010 SHALL have port req_op_i, input, 2, operation: 0 read, 1 program, 2 erase, 3 reserved.
REQ-011 SHALL have port ready_o, output, 1, block can accept a request.
REQ-012 SHALL have port rsp_valid_o, output, 1, check result valid.
REQ-013 SHALL have port rsp_ready_i, input, 1, consumer accepts result.
REQ-014 SHALL have port allow_o, output, 1, access permitted.
REQ-015 SHALL have port hit_o, output, 1, a region matched (0 = default attributes used).
REQ-016 SHALL have port hit_idx_o, output, $clog2(NumRegions) (min 1), index of matching region, 0 when hit_o=0.
REQ-017 SHALL have port err_cnt_o, output, ErrCntW, saturating count of denied responses.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN, RESP; ready_o=1 only in IDLE.
REQ-019 SHALL, in IDLE on req_i&&ready_o, capture req_addr_i and req_op_i, set index to 0, go to SCAN.
REQ-020 SHALL, in SCAN, evaluate exactly one region per cycle, index ascending from 0; lowest matching index wins.
REQ-021 SHALL define match as en=1 and base <= addr < base+size, sum computed in AddrW+1 bits (no wrap); size=0 never matches.
REQ-022 SHALL, on match at index k, register hit_o=1, hit_idx_o=k, allow_o=selected op enable, and go to RESP; remaining regions not scanned.
REQ-023 SHALL, when index NumRegions-1 evaluated without match, register hit_o=0, hit_idx_o=0, allow_o from default_cfg_i, go to RESP.
REQ-024 SHALL force allow_o=0 for req_op_i=3 regardless of attributes.
REQ-025 SHALL give latency: match at region k -> rsp_valid_o high k+2 clock edges after the accepting edge; no match -> NumRegions+1 edges.
REQ-026 SHALL hold rsp_valid_o and all result outputs stable in RESP until rsp_ready_i=1; then return to IDLE on that edge.
REQ-027 SHALL NOT accept a new request on the same edge a response completes (ready_o rises the following cycle).
REQ-028 SHALL increment err_cnt_o by 1 on each completed response (rsp_valid_o&&rsp_ready_i) with allow_o=0, saturating at all-ones.
REQ-029 SHALL sample region_cfg_i and default_cfg_i live during SCAN; changes mid-scan are applied to not-yet-evaluated regions only.
REQ-030 SHALL ignore req_i while not in IDLE.

Reset
REQ-031 SHALL, on rst_i=1 at any time including mid-SCAN or RESP, immediately enter IDLE and drive ready_o=1 and rsp_valid_o, allow_o, hit_o, hit_idx_o, err_cnt_o all 0.
REQ-032 SHALL discard any in-flight request on reset; no response produced after rst_i deasserts.

Verification
REQ-033 SHALL test: region 2 {en=1,rd_en=1,base=0x100,size=0x10}, read addr 0x10F -> rsp_valid_o 4 edges after accept, allow_o=1, hit_o=1, hit_idx_o=2.
REQ-034 SHALL test: regions 1 and 3 overlap at 0x200, region 1 prog_en=0, region 3 prog_en=1, program 0x200 -> hit_idx_o=1, allow_o=0, err_cnt_o 0->1 after handshake.
REQ-035 SHALL test: no regions enabled, default erase_en=1, erase 0xFFFF (AddrW=16) -> hit_o=0, allow_o=1, latency NumRegions+1 edges; base=0xFFF0,size=0x10 also matches 0xFFFF without wrap.
REQ-036 SHALL test: rsp_ready_i held 0 for 5 cycles -> outputs stable, ready_o=0, req_i pulses ignored.
REQ-037 SHALL test: rst_i asserted mid-SCAN -> all outputs 0, ready_o=1 same cycle, no response after release.
REQ-038 SHALL test: ErrCntW=2, five denied responses -> err_cnt_o sequence 1,2,3,3,3.
